adder_pipe_arbiter: RTL and testbench

ADDER_PIPE_ARBITER -- requirements
Module: adder_pipe_arbiter

---
 rtl/adder_pipe_arbiter.sv | 158 +++++++++++++++
 tb/tb_adder_pipe_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_arbiter.sv
// Purpose: round-robin front end for two requesters sharing an external 4-stage adder, tracking owners in a tag shadow.
// Latency: 4 advancing cycles from accept to rspN_valid; each held or stalled cycle adds one.
// Backpressure: a non-ready owner at the output stage freezes the whole pipe and drops both req ready lines.
module adder_pipe_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req0_cin,
  input  logic        req1_cin,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] rsp_res,
  output logic        rsp_cout,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] add_data1,
  output logic [31:0] add_data2,
  output logic        add_cin,
  output logic        add_valid_in,
  output logic        add_out_allow,
  output logic [3:0]  add_stop,
  output logic [3:0]  add_rst,
  input  logic [31:0] add_res,
  input  logic        add_cout,
  input  logic        add_valid_out,
  input  logic        hold,
  input  logic        flush,
  input  logic        drain,
  output logic [2:0]  inflight,
  output logic        drain_done,
  output logic        err
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] tag_vld;     // index 3 mirrors the adder output stage
  logic [3:0] tag_id;
  logic       last_grant;
  logic       err_q;
  logic       adv;
  logic       out_rdy;
  logic       grant;
  logic       any_req;
  logic       accept;
  logic [2:0] vld_cnt;
  logic       drain_fin;

  // Ready of whichever requester owns the result currently at the output stage
  assign out_rdy = tag_id[3] ? rsp1_ready : rsp0_ready;
  assign adv     = !rst && !hold && !(tag_vld[3] && !out_rdy);

  // Round-robin choice: a lone requester wins, a tie goes to the one not granted last
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_req = req0_valid || req1_valid;
  assign accept  = (state == ST_RUN) && adv && !flush && any_req;

  // Operand mux toward the adder follows the grant
  always_comb begin
    add_data1    = grant ? req1_a   : req0_a;
    add_data2    = grant ? req1_b   : req0_b;
    add_cin      = grant ? req1_cin : req0_cin;
    add_valid_in = accept;
    req0_ready   = accept && !grant;
    req1_ready   = accept &&  grant;
  end

  assign vld_cnt   = {2'b00, tag_vld[0]} + {2'b00, tag_vld[1]} +
                     {2'b00, tag_vld[2]} + {2'b00, tag_vld[3]};
  // A held pipe cannot finish draining even if empty, so completion waits for hold to drop
  assign drain_fin = (vld_cnt == 3'd0) && !hold;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: flush always wins over drain, and a flush lasts exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (flush)      state_nxt = ST_FLUSH;
        else if (drain) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (flush)          state_nxt = ST_FLUSH;
        else if (drain_fin) state_nxt = ST_RUN;
      end
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // State-dependent outputs: adder clears, response gating, drain completion pulse
  always_comb begin
    add_rst       = (rst || state == ST_FLUSH) ? 4'b0000 : 4'b1111;
    add_stop      = adv ? 4'b1111 : 4'b0000;
    add_out_allow = adv;
    drain_done    = !rst && (state == ST_DRAIN) && !flush && drain_fin;
    rsp0_valid    = !rst && (state != ST_FLUSH) && tag_vld[3] && !tag_id[3] && add_valid_out;
    rsp1_valid    = !rst && (state != ST_FLUSH) && tag_vld[3] &&  tag_id[3] && add_valid_out;
    rsp_res       = add_res;
    rsp_cout      = add_cout;
    inflight      = rst ? 3'd0 : vld_cnt;
    err           = err_q;
  end

  // Tag shadow shifts in lockstep with the adder; the output entry retires as it shifts out
  always_ff @(posedge clk) begin
    if (rst || state == ST_FLUSH) begin
      tag_vld <= 4'b0000;
      tag_id  <= 4'b0000;
    end else if (adv) begin
      tag_vld <= {tag_vld[2:0], accept};
      tag_id  <= {tag_id[2:0], grant};
    end
  end

  // Fairness pointer moves only when a grant turns into an accept
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

  // Sticky flag: the adder's output valid disagreed with the shadow on an advancing cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (adv && (tag_vld[3] != add_valid_out)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Bench for adder_pipe_arbiter: behavioural 4-stage adder plus a response scoreboard.
// Directed steps: reset, round-robin, single op latency, hold, flush, drain, stall, err, reset mid-op.
module tb_adder_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        req0_ready, req1_ready;
  logic [31:0] rsp_res;
  logic        rsp_cout;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] add_data1, add_data2;
  logic        add_cin, add_valid_in, add_out_allow;
  logic [3:0]  add_stop, add_rst;
  logic [31:0] add_res;
  logic        add_cout;
  logic        add_valid_out;
  logic        hold, flush, drain;
  logic [2:0]  inflight;
  logic        drain_done, err;

  logic        kill_vout;
  logic [3:0]  mdl_v;
  logic [32:0] mdl_d [4];

  typedef struct packed {
    logic        id;
    logic [32:0] sum;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] st_exp;

  always #5 clk = ~clk;

  adder_pipe_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_cin(req0_cin), .req1_cin(req1_cin),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp_res(rsp_res), .rsp_cout(rsp_cout),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .add_data1(add_data1), .add_data2(add_data2), .add_cin(add_cin),
    .add_valid_in(add_valid_in), .add_out_allow(add_out_allow),
    .add_stop(add_stop), .add_rst(add_rst),
    .add_res(add_res), .add_cout(add_cout), .add_valid_out(add_valid_out),
    .hold(hold), .flush(flush), .drain(drain),
    .inflight(inflight), .drain_done(drain_done), .err(err)
  );

  // Behavioural adder: per-stage active-low clear, per-stage run enable, sum formed in stage 1
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!add_rst[i]) begin
        mdl_v[i] <= 1'b0;
        mdl_d[i] <= '0;
      end else if (add_stop[i]) begin
        if (i == 0) begin
          mdl_v[0] <= add_valid_in;
          mdl_d[0] <= {1'b0, add_data1} + {1'b0, add_data2} + {32'b0, add_cin};
        end else begin
          mdl_v[i] <= mdl_v[i-1];
          mdl_d[i] <= mdl_d[i-1];
        end
      end
    end
  end

  assign add_valid_out = mdl_v[3] & !kill_vout;
  assign add_res       = mdl_d[3][31:0];
  assign add_cout      = mdl_d[3][32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any presented response with the oldest expected one; record new accepts
  task automatic sb_check();
    exp_t e;
    chk("one_ready", 64'(req0_ready & req1_ready), 64'd0);
    if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      end else begin
        e = sbq[0];
        chk("rsp1_valid_owner", 64'(rsp1_valid), 64'(e.id));
        chk("rsp0_valid_owner", 64'(rsp0_valid), 64'(!e.id));
        chk("rsp_data", 64'({rsp_cout, rsp_res}), 64'(e.sum));
        if ((!e.id && rsp0_valid && rsp0_ready) || (e.id && rsp1_valid && rsp1_ready))
          void'(sbq.pop_front());
      end
    end
    if (req0_valid && req0_ready === 1'b1) begin
      e.id  = 1'b0;
      e.sum = {1'b0, req0_a} + {1'b0, req0_b} + {32'b0, req0_cin};
      sbq.push_back(e);
    end
    if (req1_valid && req1_ready === 1'b1) begin
      e.id  = 1'b1;
      e.sum = {1'b0, req1_a} + {1'b0, req1_b} + {32'b0, req1_cin};
      sbq.push_back(e);
    end
  endtask

  task automatic mid();
    @(negedge clk);
    sb_check();
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    mid();
    fin();
  endtask

  task automatic rnd0();
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom_range(1));
  endtask

  task automatic rnd1();
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom_range(1));
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0; drain = 1'b0; kill_vout = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_cin = 1'b0; req1_cin = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset state with both requesters asking
    mid();
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_add_rst", 64'(add_rst), 64'h0);
    chk("rst_add_stop", 64'(add_stop), 64'h0);
    chk("rst_valid_in", 64'(add_valid_in), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_drain_done", 64'(drain_done), 64'd0);
    chk("rst_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
    fin();
    step();
    rst = 1'b0;

    // Round-robin with both always valid: 0,1,0,1 ...
    for (int i = 0; i < 6; i++) begin
      rnd0(); rnd1();
      mid();
      chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
      chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
      fin();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (8) step();
    chk("rr_drained", 64'(sbq.size()), 64'd0);

    // Single op 1 + -5, four-cycle latency
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'hFFFF_FFFB; req0_cin = 1'b0;
    mid();
    chk("lat_accept", 64'(req0_ready), 64'd1);
    fin();
    req0_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("lat_rsp0_valid", 64'(rsp0_valid), 64'(k == 4));
      chk("lat_rsp1_valid", 64'(rsp1_valid), 64'd0);
      if (k == 4) chk("lat_res", 64'({rsp_cout, rsp_res}), 64'h0_FFFF_FFFC);
      fin();
    end

    // Hold for two cycles after an accept
    req0_valid = 1'b1; rnd0();
    mid();
    chk("hold_accept", 64'(req0_ready), 64'd1);
    fin();
    hold = 1'b1; rnd0();
    for (int k = 1; k <= 2; k++) begin
      mid();
      chk("hold_stop", 64'(add_stop), 64'h0);
      chk("hold_inflight", 64'(inflight), 64'd1);
      chk("hold_ready0", 64'(req0_ready), 64'd0);
      fin();
    end
    hold = 1'b0; req0_valid = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      mid();
      chk("hold_rsp0_valid", 64'(rsp0_valid), 64'(k == 6));
      fin();
    end

    // Flush with three ops in flight
    for (int k = 0; k < 3; k++) begin
      req0_valid = 1'b1; rnd0();
      mid();
      chk("fl_accept", 64'(req0_ready), 64'd1);
      fin();
    end
    flush = 1'b1; rnd0();
    mid();
    chk("fl_inflight3", 64'(inflight), 64'd3);
    chk("fl_ready_pulse", 64'(req0_ready), 64'd0);
    fin();
    flush = 1'b0;
    mid();
    chk("fl_add_rst", 64'(add_rst), 64'h0);
    chk("fl_rsp0_valid", 64'(rsp0_valid), 64'd0);
    chk("fl_ready_state", 64'(req0_ready), 64'd0);
    fin();
    sbq.delete();
    mid();
    chk("fl_inflight0", 64'(inflight), 64'd0);
    chk("fl_add_rst_run", 64'(add_rst), 64'hF);
    chk("fl_next_accept", 64'(req0_ready), 64'd1);
    fin();
    req0_valid = 1'b0;
    repeat (5) step();
    chk("fl_drained", 64'(sbq.size()), 64'd0);

    // Drain with two ops in flight
    req0_valid = 1'b1; rnd0();
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; rnd1();
    mid();
    chk("dr_accept1", 64'(req1_ready), 64'd1);
    fin();
    req1_valid = 1'b0; drain = 1'b1;
    step();
    drain = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rnd0(); rnd1();
    for (int c = 3; c <= 6; c++) begin
      mid();
      chk("dr_ready0", 64'(req0_ready), 64'd0);
      chk("dr_ready1", 64'(req1_ready), 64'd0);
      chk("dr_done", 64'(drain_done), 64'(c == 6));
      fin();
    end
    req1_valid = 1'b0;
    mid();
    chk("dr_done_once", 64'(drain_done), 64'd0);
    chk("dr_run_accept", 64'(req0_ready), 64'd1);
    fin();
    req0_valid = 1'b0;
    repeat (6) step();
    chk("dr_drained", 64'(sbq.size()), 64'd0);

    // Output stall: req1 result waits at stage 4 while rsp1_ready is low
    rsp1_ready = 1'b0; req1_valid = 1'b1; rnd1();
    st_exp = {1'b0, req1_a} + {1'b0, req1_b} + {32'b0, req1_cin};
    mid();
    chk("st_accept", 64'(req1_ready), 64'd1);
    fin();
    req1_valid = 1'b0;
    repeat (3) step();
    req0_valid = 1'b1; rnd0();
    for (int c = 4; c <= 6; c++) begin
      mid();
      chk("st_rsp1_valid", 64'(rsp1_valid), 64'd1);
      chk("st_stop", 64'(add_stop), 64'h0);
      chk("st_ready0", 64'(req0_ready), 64'd0);
      chk("st_res_stable", 64'({rsp_cout, rsp_res}), 64'(st_exp));
      fin();
    end
    rsp1_ready = 1'b1;
    mid();
    chk("st_release", 64'(rsp1_valid), 64'd1);
    chk("st_accept_after", 64'(req0_ready), 64'd1);
    fin();
    req0_valid = 1'b0;
    repeat (5) step();
    chk("st_drained", 64'(sbq.size()), 64'd0);

    // Shadow mismatch sets sticky err
    mid();
    chk("err_pre", 64'(err), 64'd0);
    fin();
    req0_valid = 1'b1; rnd0();
    step();
    req0_valid = 1'b0;
    repeat (3) step();
    kill_vout = 1'b1;
    mid();
    chk("err_rsp0_suppressed", 64'(rsp0_valid), 64'd0);
    fin();
    kill_vout = 1'b0;
    sbq.delete();
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("err_sticky", 64'(err), 64'd1);
      fin();
    end

    // Reset mid-operation discards in-flight work
    req0_valid = 1'b1; rnd0();
    step();
    req0_valid = 1'b0; req1_valid = 1'b1; rnd1();
    step();
    req1_valid = 1'b0; rst = 1'b1;
    mid();
    chk("rst2_inflight", 64'(inflight), 64'd0);
    fin();
    sbq.delete();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("rst2_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
      chk("rst2_err_clear", 64'(err), 64'd0);
      fin();
    end
    chk("end_inflight", 64'(inflight), 64'd0);
    chk("end_queue", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
